// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller and its datapath.
// ctrl_for() maps each FSM state to the control word that is registered with it.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // fetch/jump/branch are qualified later by mem_ready/zero; retire marks write-back states
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       fetch;
        logic       jump;
        logic       branch;
        logic       reg_write;
        logic       retire;
        logic       trap;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic ctrl_t ctrl_for(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.fetch      = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALURES;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = RES_MEMDATA;
                c.reg_write  = 1'b1;
                c.retire     = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.adr_src   = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
                c.retire     = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a  = SRCA_RS1;
                c.alu_src_b  = SRCB_RS2;
                c.alu_op     = ALUOP_SUB;
                c.result_src = RES_ALUOUT;
                c.branch     = 1'b1;
                c.retire     = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALUOUT;
                c.jump       = 1'b1;
            end
            S_TRAP: c.trap = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [1:0] imm_sel(logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory control bundle; master is the controller side.
interface multicycle_controller_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_write;
    logic             adr_src;
    logic             ir_write;
    logic             pc_write;
    logic             reg_write;
    logic [1:0]       result_src;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       imm_src;
    logic             trap;
    logic [CNT_W-1:0] instret;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op, imm_src, trap, instret
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op, imm_src, trap, instret
    );
endinterface

// File: rtl/instret_counter.sv
// Retired-instruction counter, wraps naturally at 2^CNT_W.
module instret_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign count_d = count_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch, decode, execute and write-back
// over a shared ALU and a single memory port; sticky trap on illegal opcodes.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    multicycle_controller_if.master  ctl
);
    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_q;
    logic   req_done;
    logic   retire;

    // A request only completes when it is actually being presented.
    assign req_done = ctrl_q.mem_req & ctl.mem_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (req_done) state_d = S_DECODE;
            S_DECODE: begin
                case (ctl.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (ctl.opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (req_done) state_d = S_MEMWB;
            S_MEMWRITE: if (req_done) state_d = S_FETCH;
            S_EXECR, S_EXECI, S_JAL:  state_d = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BEQ:  state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
    end

    // Control word is registered alongside the state; reset clears it so every strobe drops at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_FETCH;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_for(state_d);
        end
    end

    assign ctl.mem_req    = ctrl_q.mem_req;
    assign ctl.mem_write  = ctrl_q.mem_write;
    assign ctl.adr_src    = ctrl_q.adr_src;
    assign ctl.reg_write  = ctrl_q.reg_write;
    assign ctl.result_src = ctrl_q.result_src;
    assign ctl.alu_src_a  = ctrl_q.alu_src_a;
    assign ctl.alu_src_b  = ctrl_q.alu_src_b;
    assign ctl.alu_op     = ctrl_q.alu_op;
    assign ctl.trap       = ctrl_q.trap;
    assign ctl.ir_write   = ctrl_q.fetch & req_done;
    assign ctl.pc_write   = (ctrl_q.fetch & req_done) | ctrl_q.jump | (ctrl_q.branch & ctl.zero);
    assign ctl.imm_src    = imm_sel(ctl.opcode);

    assign retire = ctrl_q.retire | (ctrl_q.mem_write & req_done);

    instret_counter #(
        .CNT_W (CNT_W)
    ) u_instret (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (retire),
        .count (ctl.instret)
    );
endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: per-instruction expectations come from
// cycle/strobe budgets computed from opcode, memory wait counts and the zero flag.
module tb_multicycle_controller;
    localparam int CNT_W = 4;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b0000000;

    logic clk = 1'b0;
    logic rstn;
    int   n_checks;
    int   n_errors;
    int   exp_instret;

    always #5 clk = ~clk;

    multicycle_controller_if #(.CNT_W(CNT_W)) ctl ();

    multicycle_controller #(.CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .ctl  (ctl)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(logic [6:0] op);
        return op inside {LW, SW, RT, IT, BQ, JL};
    endfunction

    function automatic int base_cycles(logic [6:0] op);
        if (op == BQ) return 3;
        if (op == LW) return 5;
        if (is_legal(op)) return 4;
        return 2;
    endfunction

    function automatic logic [1:0] exp_imm(logic [6:0] op);
        if (op == SW) return 2'b01;
        if (op == BQ) return 2'b10;
        if (op == JL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [5:0] strobes();
        return {ctl.mem_req, ctl.mem_write, ctl.adr_src, ctl.ir_write, ctl.pc_write, ctl.reg_write};
    endfunction

    task automatic wait_first_req();
        int n;
        n = 0;
        while (!ctl.mem_req && n < 8) begin
            @(negedge clk);
            n++;
        end
        check_eq("first_req_latency", n, 1);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        check_eq("rst_strobes", strobes(), 0);
        check_eq("rst_trap", ctl.trap, 0);
        check_eq("rst_instret", ctl.instret, 0);
        exp_instret     = 0;
        ctl.mem_ready   = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        wait_first_req();
    endtask

    // Entered at a negedge with the DUT in the first request cycle of FETCH.
    task automatic run_instr(input logic [6:0] op, input int wf, input int wd,
                             input logic z, input int abort_at);
        int  cycles, req_seen, wcnt, w;
        int  nreq, nmw, nrw, npw, nir, rw_pos, imm_bad, adr_bad;
        int  e_req, e_mw, e_rw, e_pw;
        bit  dphase, data_op;
        logic [1:0] rs_at_rw;
        logic [5:0] pcw_sel;

        data_op = (op == LW) || (op == SW);
        cycles  = base_cycles(op) + wf + (data_op ? wd : 0);
        req_seen = 0; wcnt = 0;
        nreq = 0; nmw = 0; nrw = 0; npw = 0; nir = 0;
        rw_pos = -1; imm_bad = 0; adr_bad = 0;
        rs_at_rw = 2'b11; pcw_sel = '0;
        ctl.opcode = op;
        ctl.zero   = z;
        check_eq("start_req", ctl.mem_req, 1);

        for (int c = 0; c < cycles; c++) begin
            dphase = (req_seen != 0);
            if (ctl.mem_req) begin
                w = dphase ? wd : wf;
                if (wcnt < w) begin
                    ctl.mem_ready = 1'b0;
                    wcnt++;
                end else begin
                    ctl.mem_ready = 1'b1;
                    wcnt = 0;
                    req_seen++;
                end
            end else begin
                ctl.mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            if (ctl.mem_req) begin
                nreq++;
                if (ctl.adr_src !== dphase) adr_bad++;
            end
            if (ctl.mem_write) nmw++;
            if (ctl.reg_write) begin
                nrw++;
                rw_pos   = c;
                rs_at_rw = ctl.result_src;
            end
            if (ctl.pc_write) begin
                npw++;
                if (!ctl.ir_write) pcw_sel = {ctl.alu_src_a, ctl.alu_src_b, ctl.alu_op};
            end
            if (ctl.ir_write) nir++;
            if (ctl.imm_src !== exp_imm(op)) imm_bad++;
            if (c == abort_at) begin
                rstn = 1'b0;
                #1;
                check_eq("abort_strobes", strobes(), 0);
                check_eq("abort_instret", ctl.instret, 0);
                exp_instret   = 0;
                ctl.mem_ready = 1'b0;
                @(negedge clk);
                rstn = 1'b1;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end

        e_req = 1 + wf + (data_op ? 1 + wd : 0);
        e_mw  = (op == SW) ? 1 + wd : 0;
        e_rw  = (op inside {LW, RT, IT, JL}) ? 1 : 0;
        e_pw  = 1 + ((op == JL) ? 1 : 0) + ((op == BQ && z) ? 1 : 0);
        check_eq("mem_req_cycles", nreq, e_req);
        check_eq("mem_write_cycles", nmw, e_mw);
        check_eq("reg_write_cycles", nrw, e_rw);
        check_eq("pc_write_cycles", npw, e_pw);
        check_eq("ir_write_cycles", nir, 1);
        check_eq("imm_src_bad", imm_bad, 0);
        check_eq("adr_src_bad", adr_bad, 0);
        if (e_rw != 0) begin
            check_eq("reg_write_pos", rw_pos, cycles - 1);
            check_eq("wb_result_src", rs_at_rw, (op == LW) ? 2'b01 : 2'b00);
        end
        if (op == JL) check_eq("jal_sel", pcw_sel, 6'b01_10_00);
        if (op == BQ && z) check_eq("beq_sel", pcw_sel, 6'b10_00_01);
        if (is_legal(op)) exp_instret = (exp_instret + 1) % (1 << CNT_W);
        check_eq("instret", ctl.instret, exp_instret);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] legal_ops [6];
        int n_bad, n_trap;
        legal_ops = '{LW, SW, RT, IT, BQ, JL};
        n_checks = 0;
        n_errors = 0;
        exp_instret = 0;
        rstn = 1'b0;
        ctl.opcode = RT;
        ctl.zero = 1'b0;
        ctl.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        do_reset();

        run_instr(LW, 0, 0, 1'b0, -1);
        run_instr(SW, 0, 2, 1'b0, -1);
        run_instr(BQ, 0, 0, 1'b1, -1);
        run_instr(BQ, 0, 0, 1'b0, -1);
        run_instr(JL, 1, 0, 1'b1, -1);
        run_instr(RT, 0, 0, 1'b1, -1);
        run_instr(IT, 2, 0, 1'b0, -1);
        run_instr(LW, 1, 2, 1'b0, -1);

        do_reset();
        for (int i = 0; i < 16; i++) run_instr(RT, 0, 0, 1'b0, -1);
        check_eq("wrap16", ctl.instret, 0);

        for (int i = 0; i < 60; i++) begin
            run_instr(legal_ops[$urandom_range(0, 5)], int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), -1);
        end

        run_instr(LW, 0, 3, 1'b0, 4);
        run_instr(RT, 0, 0, 1'b0, -1);

        run_instr(BAD, 1, 0, 1'b1, -1);
        n_bad = 0;
        n_trap = 0;
        for (int i = 0; i < 20; i++) begin
            ctl.mem_ready = 1'($urandom_range(0, 1));
            #1;
            if (strobes() != 6'd0) n_bad++;
            if (ctl.trap) n_trap++;
            @(negedge clk);
        end
        check_eq("trap_strobes", n_bad, 0);
        check_eq("trap_sticky", n_trap, 20);
        check_eq("trap_instret", ctl.instret, exp_instret);
        do_reset();
        run_instr(SW, 0, 1, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multicycle RV32I core variant: sequences one shared ALU, one unified instruction/data memory port and the register file over several cycles per instruction. Sits beside the datapath in place of the single-cycle main decoder and drives every mux select, write strobe and memory request. Also raises a sticky trap on unsupported opcodes and counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  core clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- opcode  in  7  instr[6:0] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request valid
- mem_write  out  1  request is a store
- adr_src  out  1  0 = PC, 1 = ALU result register
- ir_write  out  1  load instruction register and old PC
- pc_write  out  1  load PC from the result bus
- reg_write  out  1  register file write enable
- result_src  out  2  00 ALUOut, 01 memory data, 10 ALU result
- alu_src_a  out  2  00 PC, 01 old PC, 10 rs1
- alu_src_b  out  2  00 rs2, 01 immediate, 10 constant 4
- alu_op  out  2  00 add, 01 sub/branch, 10 funct-decoded
- imm_src  out  2  00 I, 01 S, 10 B, 11 J
- trap  out  1  illegal opcode seen, sticky
- instret  out  CNT_W  retired-instruction count

## Operation
- Supported opcodes: 0000011 lw, 0100011 sw, 0110011 R, 0010011 I, 1100011 beq, 1101111 jal. Any other opcode is illegal.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP.
- FETCH: mem_req=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10. Holds until mem_ready; in the mem_ready cycle ir_write=1, pc_write=1, then → DECODE.
- DECODE: a=01, b=01, alu_op=00 (branch/jump target). lw/sw → MEMADR, R → EXECR, I → EXECI, beq → BEQ, jal → JAL, illegal → TRAP.
- MEMADR: a=10, b=01, alu_op=00; → MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: mem_req=1, adr_src=1; holds until mem_ready, then → MEMWB.
- MEMWB: result_src=01, reg_write=1; → FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1; holds until mem_ready, then → FETCH.
- EXECR: a=10, b=00, alu_op=10. EXECI: a=10, b=01, alu_op=10. Both → ALUWB.
- ALUWB: result_src=00, reg_write=1; → FETCH.
- BEQ: a=10, b=00, alu_op=01, result_src=00, pc_write=zero; → FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1; → ALUWB.
- TRAP: trap=1, all strobes 0; remains until reset.
- imm_src: combinational from opcode in every state (lw/I 00, sw 01, beq 10, jal 11, else 00).
- Selects not listed for a state are 00/0. Strobes (mem_req, mem_write, ir_write, pc_write, reg_write) are 0 outside the states listed.
- instret increments by 1 on retire: MEMWB, ALUWB, MEMWRITE with mem_ready, BEQ. Wraps from 2^CNT_W-1 to 0.

## Timing
- Reset (rstn low, async): state=FETCH, instret=0, trap=0; all strobes forced 0 while rstn low. First mem_req in the first cycle after rstn rises.
- Zero-wait memory: beq 3 cycles, sw/R/I/jal 4, lw 5. Each mem_ready-low cycle in FETCH/MEMREAD/MEMWRITE adds one cycle.
- mem_req, adr_src and mem_write are stable for the whole request; deasserted the cycle after mem_ready.
- mem_ready outside a request state is ignored.
- ir_write/pc_write in FETCH are asserted only in the mem_ready cycle.
- Reset mid-instruction aborts immediately; no partial write-back after release.

## Structure
- Package ctrl_pkg: state enum, opcode localparams, result_src/alu_src_a/alu_src_b/alu_op/imm_src encodings, shared with the datapath.
- One sub-module: instret_counter (CNT_W, inc, rstn, clk → count).

## Test plan
- lw, mem_ready tied 1: exactly 5 cycles FETCH→DECODE→MEMADR→MEMREAD→MEMWB; reg_write=1, result_src=01 only in cycle 5; instret 0→1.
- sw with mem_ready low 2 cycles in MEMWRITE: mem_req=mem_write=adr_src=1 held 3 cycles; no reg_write; total 6 cycles.
- beq with zero=1, then zero=0: pc_write=1 in BEQ cycle only for the first; each takes 3 cycles; instret +2.
- jal: JAL cycle pc_write=1, a=01, b=10; ALUWB reg_write=1; imm_src=11 throughout.
- Opcode 0000000: DECODE→TRAP, trap=1 sticky, no mem_req for 20 cycles, instret unchanged; rstn pulse → FETCH, trap=0.
- CNT_W=4 with 16 R-type instructions: instret wraps 15→0; rstn asserted during MEMREAD forces strobes 0 within the same cycle.
